// File: rtl/aes_round_seq_pkg.sv
// Shared encodings, round counts and Rcon arithmetic for the AES round sequencer.
package aes_seq_pkg;

  localparam logic [1:0] KL_128 = 2'b00;
  localparam logic [1:0] KL_192 = 2'b01;
  localparam logic [1:0] KL_256 = 2'b10;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Last Rcon consumed by each key schedule; decryption rewinds from here.
  localparam logic [7:0] RCON_LAST_128 = 8'h36;
  localparam logic [7:0] RCON_LAST_192 = 8'h80;
  localparam logic [7:0] RCON_LAST_256 = 8'h40;
  localparam logic [7:0] RCON_FIRST    = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  function automatic int cw_of(input int cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] rc);
    return {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] rc);
    return rc[0] ? (((rc ^ 8'h1b) >> 1) | 8'h80) : (rc >> 1);
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return NR_192;
      KL_256:  return NR_256;
      default: return NR_128;
    endcase
  endfunction

  function automatic logic [7:0] rcon_init(input logic [1:0] kl, input logic dec);
    if (!dec) return RCON_FIRST;
    case (kl)
      KL_192:  return RCON_LAST_192;
      KL_256:  return RCON_LAST_256;
      default: return RCON_LAST_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_seq_if.sv
// Control/status bundle between the AES core controller and the round sequencer.
interface aes_round_seq_if #(
  parameter int CW = 1
);
  logic          start;
  logic [1:0]    key_len;
  logic          decrypt;
  logic          rcon_step;
  logic          busy;
  logic          done;
  logic [3:0]    rnd_idx;
  logic [CW-1:0] col_idx;
  logic          rnd_tick;
  logic          first_rnd;
  logic          final_rnd;
  logic [7:0]    rcon;

  modport master (
    output start, key_len, decrypt, rcon_step,
    input  busy, done, rnd_idx, col_idx, rnd_tick, first_rnd, final_rnd, rcon
  );

  modport slave (
    input  start, key_len, decrypt, rcon_step,
    output busy, done, rnd_idx, col_idx, rnd_tick, first_rnd, final_rnd, rcon
  );
endinterface

// File: rtl/aes_round_seq_rcon_gen.sv
// Round-constant register: load wins over step; dir=1 steps backward (key-schedule rewind).
module rcon_gen
  import aes_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_step,
  input  logic       i_dir,
  output logic [7:0] o_rcon
);

  logic [7:0] r_rcon;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rcon <= RCON_FIRST;
    end else if (i_load) begin
      r_rcon <= i_load_val;
    end else if (i_step) begin
      r_rcon <= i_dir ? inv_xtime(r_rcon) : xtime(r_rcon);
    end
  end

  assign o_rcon = r_rcon;

endmodule

// File: rtl/aes_round_seq.sv
// AES round sequencer: counts Nr+1 round slots folded over CYC_PER_RND cycles and owns Rcon.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for start
//   RUN     | stepping col_idx/rnd_idx through the Nr+1 round slots
//   DONE    | one-cycle done pulse; start here re-enters RUN directly
module aes_round_seq
  import aes_seq_pkg::*;
#(
  parameter int CYC_PER_RND = 1,
  parameter int CW          = cw_of(CYC_PER_RND)
) (
  input logic            clk,
  input logic            rst,
  aes_round_seq_if.slave bus
);

  localparam logic [CW-1:0] COL_LAST = CW'(CYC_PER_RND - 1);

  seq_state_e    r_state;
  seq_state_e    w_state_nxt;
  logic [3:0]    r_rnd_idx;
  logic [3:0]    r_nr;
  logic [CW-1:0] r_col_idx;
  logic          r_dec;

  logic          w_run;
  logic          w_accept;
  logic          w_col_wrap;
  logic          w_last;
  logic          w_step;
  logic [7:0]    w_load_val;
  logic [7:0]    w_rcon;

  assign w_run      = (r_state == ST_RUN);
  assign w_accept   = bus.start && !w_run;
  assign w_col_wrap = w_run && (r_col_idx == COL_LAST);
  assign w_last     = w_col_wrap && (r_rnd_idx == r_nr);
  assign w_step     = bus.rcon_step && w_run;
  assign w_load_val = rcon_init(bus.key_len, bus.decrypt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = bus.start ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // rnd_idx holds at Nr after the last slot so DONE still reports it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rnd_idx <= 4'd0;
      r_col_idx <= '0;
      r_nr      <= NR_128;
      r_dec     <= 1'b0;
    end else if (w_accept) begin
      r_rnd_idx <= 4'd0;
      r_col_idx <= '0;
      r_nr      <= nr_of(bus.key_len);
      r_dec     <= bus.decrypt;
    end else if (w_run) begin
      if (w_col_wrap) begin
        r_col_idx <= '0;
        if (!w_last) r_rnd_idx <= r_rnd_idx + 4'd1;
      end else begin
        r_col_idx <= r_col_idx + 1'b1;
      end
    end
  end

  rcon_gen u_rcon_gen (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_accept),
    .i_load_val(w_load_val),
    .i_step    (w_step),
    .i_dir     (r_dec),
    .o_rcon    (w_rcon)
  );

  assign bus.busy      = w_run;
  assign bus.done      = (r_state == ST_DONE);
  assign bus.rnd_idx   = r_rnd_idx;
  assign bus.col_idx   = r_col_idx;
  assign bus.rnd_tick  = w_col_wrap;
  assign bus.first_rnd = w_run && (r_rnd_idx == 4'd0);
  assign bus.final_rnd = w_run && (r_rnd_idx == r_nr);
  assign bus.rcon      = w_rcon;

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq with C=1 and C=4 instances and an Rcon scoreboard.
module tb_aes_round_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_round_seq_if #(.CW(1)) bus1 ();
  aes_round_seq_if #(.CW(2)) bus4 ();

  aes_round_seq #(.CYC_PER_RND(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  aes_round_seq #(.CYC_PER_RND(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb_q[$];
  logic [7:0] m_rc;
  logic       m_dec;
  bit         seen_done;

  function automatic logic [7:0] m_fwd(input logic [7:0] a);
    logic [8:0] t;
    t = {a, 1'b0};
    if (t[8]) t = t ^ 9'h11b;
    return t[7:0];
  endfunction

  // Backward step as the unique preimage of the forward step.
  function automatic logic [7:0] m_bwd(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 0; b < 256; b++)
      if (m_fwd(8'(b)) == a) r = 8'(b);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start1(input logic [1:0] kl, input logic dec, input logic also_step);
    bus1.start     = 1'b1;
    bus1.key_len   = kl;
    bus1.decrypt   = dec;
    bus1.rcon_step = also_step;
    m_dec = dec;
    if (!dec) m_rc = 8'h01;
    else if (kl == 2'b01) m_rc = 8'h80;
    else if (kl == 2'b10) m_rc = 8'h40;
    else m_rc = 8'h36;
    tick();
    bus1.start     = 1'b0;
    bus1.rcon_step = 1'b0;
    chk("rcon_load", 32'(bus1.rcon), 32'(m_rc));
  endtask

  task automatic cyc1(input bit stp);
    bus1.rcon_step = stp;
    if (stp) begin
      m_rc = m_dec ? m_bwd(m_rc) : m_fwd(m_rc);
      sb_q.push_back(m_rc);
    end
    tick();
    bus1.rcon_step = 1'b0;
    if (stp) begin
      if (sb_q.size() == 0) chk("sb_empty", 32'(0), 32'(1));
      else chk("rcon_step", 32'(bus1.rcon), 32'(sb_q.pop_front()));
    end
  endtask

  initial begin
    bus1.start = 0; bus1.key_len = 0; bus1.decrypt = 0; bus1.rcon_step = 0;
    bus4.start = 0; bus4.key_len = 0; bus4.decrypt = 0; bus4.rcon_step = 0;
    m_rc = 8'h01; m_dec = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus1.busy), 32'(0));
    chk("rst_done", 32'(bus1.done), 32'(0));
    chk("rst_rnd", 32'(bus1.rnd_idx), 32'(0));
    chk("rst_col", 32'(bus1.col_idx), 32'(0));
    chk("rst_tick", 32'(bus1.rnd_tick), 32'(0));
    chk("rst_first", 32'(bus1.first_rnd), 32'(0));
    chk("rst_final", 32'(bus1.final_rnd), 32'(0));
    chk("rst_rcon", 32'(bus1.rcon), 32'(8'h01));
    chk("rst_rcon4", 32'(bus4.rcon), 32'(8'h01));
    rst = 1'b0;
    tick();

    // AES-128 encrypt, 9 forward steps
    start1(2'b00, 1'b0, 1'b0);
    for (int k = 0; k <= 10; k++) begin
      chk("a_busy", 32'(bus1.busy), 32'(1));
      chk("a_rnd", 32'(bus1.rnd_idx), 32'(k));
      chk("a_first", 32'(bus1.first_rnd), 32'(k == 0));
      chk("a_final", 32'(bus1.final_rnd), 32'(k == 10));
      chk("a_tick", 32'(bus1.rnd_tick), 32'(1));
      chk("a_done", 32'(bus1.done), 32'(0));
      cyc1(k < 9);
    end
    chk("a_done_pulse", 32'(bus1.done), 32'(1));
    chk("a_done_busy", 32'(bus1.busy), 32'(0));
    chk("a_done_final", 32'(bus1.final_rnd), 32'(0));
    chk("a_rcon_last", 32'(bus1.rcon), 32'(8'h36));
    tick();
    chk("a_idle_done", 32'(bus1.done), 32'(0));
    chk("a_idle_busy", 32'(bus1.busy), 32'(0));

    // AES-256 decrypt, rewind past 0x01
    start1(2'b10, 1'b1, 1'b0);
    chk("b_rcon_init", 32'(bus1.rcon), 32'(8'h40));
    for (int k = 0; k <= 14; k++) begin
      chk("b_rnd", 32'(bus1.rnd_idx), 32'(k));
      chk("b_final", 32'(bus1.final_rnd), 32'(k == 14));
      chk("b_done", 32'(bus1.done), 32'(0));
      cyc1(k < 7);
      if (k == 5) chk("b_rcon_01", 32'(bus1.rcon), 32'(8'h01));
      if (k == 6) chk("b_rcon_8d", 32'(bus1.rcon), 32'(8'h8d));
    end
    chk("b_done_pulse", 32'(bus1.done), 32'(1));
    tick();

    // start mid-RUN ignored, then restart from the done cycle
    start1(2'b00, 1'b0, 1'b0);
    for (int k = 0; k <= 10; k++) begin
      chk("c_rnd", 32'(bus1.rnd_idx), 32'(k));
      chk("c_final", 32'(bus1.final_rnd), 32'(k == 10));
      if (k == 3) begin
        bus1.start = 1'b1; bus1.key_len = 2'b10; bus1.decrypt = 1'b1;
      end
      cyc1(k == 1);
      bus1.start = 1'b0;
      if (k == 3) chk("c_rcon_kept", 32'(bus1.rcon), 32'(8'h02));
    end
    chk("c_done_pulse", 32'(bus1.done), 32'(1));
    start1(2'b00, 1'b0, 1'b0);
    chk("c_re_busy", 32'(bus1.busy), 32'(1));
    chk("c_re_rnd", 32'(bus1.rnd_idx), 32'(0));
    chk("c_re_first", 32'(bus1.first_rnd), 32'(1));
    chk("c_re_done", 32'(bus1.done), 32'(0));

    // async reset mid-cycle at rnd_idx 5
    for (int k = 0; k < 5; k++) cyc1(k < 3);
    chk("d_pre_rnd", 32'(bus1.rnd_idx), 32'(5));
    chk("d_pre_rcon", 32'(bus1.rcon), 32'(8'h08));
    #3;
    rst = 1'b1;
    #1;
    chk("d_busy", 32'(bus1.busy), 32'(0));
    chk("d_rnd", 32'(bus1.rnd_idx), 32'(0));
    chk("d_col", 32'(bus1.col_idx), 32'(0));
    chk("d_tick", 32'(bus1.rnd_tick), 32'(0));
    chk("d_first", 32'(bus1.first_rnd), 32'(0));
    chk("d_final", 32'(bus1.final_rnd), 32'(0));
    chk("d_done", 32'(bus1.done), 32'(0));
    chk("d_rcon", 32'(bus1.rcon), 32'(8'h01));
    tick();
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      seen_done = seen_done | bus1.done | bus1.busy;
    end
    chk("d_no_done", 32'(seen_done), 32'(0));

    // key_len 11 decrypt, step concurrent with start
    start1(2'b11, 1'b1, 1'b1);
    chk("e_rcon", 32'(bus1.rcon), 32'(8'h36));
    for (int k = 0; k <= 10; k++) begin
      chk("e_final", 32'(bus1.final_rnd), 32'(k == 10));
      cyc1(1'b0);
    end
    chk("e_done_pulse", 32'(bus1.done), 32'(1));
    tick();

    // C=4, AES-192 encrypt
    bus4.start = 1'b1; bus4.key_len = 2'b01; bus4.decrypt = 1'b0;
    tick();
    bus4.start = 1'b0;
    chk("f_rcon_init", 32'(bus4.rcon), 32'(8'h01));
    for (int c = 0; c < 52; c++) begin
      chk("f_rnd", 32'(bus4.rnd_idx), 32'(c / 4));
      chk("f_col", 32'(bus4.col_idx), 32'(c % 4));
      chk("f_tick", 32'(bus4.rnd_tick), 32'((c % 4) == 3));
      chk("f_final", 32'(bus4.final_rnd), 32'((c / 4) == 12));
      chk("f_done", 32'(bus4.done), 32'(0));
      bus4.rcon_step = (c < 3);
      tick();
    end
    chk("f_done_pulse", 32'(bus4.done), 32'(1));
    chk("f_done_busy", 32'(bus4.busy), 32'(0));
    chk("f_rcon", 32'(bus4.rcon), 32'(8'h08));
    bus4.rcon_step = 1'b1;
    tick();
    tick();
    bus4.rcon_step = 1'b0;
    chk("f_idle_busy", 32'(bus4.busy), 32'(0));
    chk("f_idle_rcon", 32'(bus4.rcon), 32'(8'h08));
    chk("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_seq.md
# aes_round_seq

Parametrised AES round sequencer and bidirectional round-constant generator for the AES core. Counts the Nr+1 round slots of an AES-128/192/256 operation, folded over a configurable number of datapath cycles per round. Exposes first/final-round flags, slot and column indices, and a start/busy/done handshake. Drives Rcon forward for encryption key expansion and backward for decryption key-schedule rewind; the key-expansion engine steps it explicitly.

## Interface
- CYC_PER_RND, default 1: datapath cycles per round slot (1 = full-round datapath, 4 = 32-bit column datapath); legal ≥1.
- CW, default max(1, clog2(CYC_PER_RND)): width of col_idx (derived).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin operation; accepted when not in RUN.
- key_len  in  2  00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = treated as AES-128; sampled with accepted start.
- decrypt  in  1  direction; sampled with accepted start.
- rcon_step  in  1  advance Rcon one step (forward if enc, backward if dec); honoured only in RUN.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after last slot.
- rnd_idx  out  4  current slot, 0..Nr, always counts up.
- col_idx  out  CW  sub-cycle within slot, 0..CYC_PER_RND-1.
- rnd_tick  out  1  high on last sub-cycle of each slot.
- first_rnd  out  1  RUN and rnd_idx==0.
- final_rnd  out  1  RUN and rnd_idx==Nr.
- rcon  out  8  current round constant.

## Operation
- FSM states: IDLE, RUN, DONE. Transitions: IDLE --start--> RUN; RUN --(rnd_idx==Nr and col_idx==CYC_PER_RND-1)--> DONE; DONE --start--> RUN, otherwise DONE -> IDLE.
- Nr from latched key_len: 10, 12, 14 (11 -> 10).
- On accepted start: rnd_idx=0, col_idx=0. Rcon loads 0x01 for encrypt, or the last-used value for decrypt: 0x36 (128), 0x80 (192), 0x40 (256).
- In RUN, col_idx increments each cycle and wraps at CYC_PER_RND-1. rnd_idx increments on wrap.
- Rcon forward step is xtime: (rc<<1) ^ (rc[7] ? 0x1b : 0).
- Rcon backward step: rc[0] ? ((rc^0x1b)>>1)|0x80 : rc>>1. Stepping backward from 0x01 yields 0x8d; no saturation either direction.
- start while in RUN is ignored; key_len and decrypt are not re-sampled.
- start in the same cycle as rcon_step: load wins.
- rcon_step in IDLE or DONE is ignored.
- Reset values: state IDLE, busy 0, done 0, rnd_idx 0, col_idx 0, rnd_tick 0, first_rnd 0, final_rnd 0, rcon 0x01. Reset mid-operation aborts immediately; no done pulse.

## Timing
- start sampled at edge T -> busy, first_rnd, rnd_idx 0 valid from T+1.
- Slot k occupies cycles T+1+k·C .. T+(k+1)·C, where C = CYC_PER_RND.
- rcon_step at edge E -> new rcon visible from E+1.
- done high in cycle T+1+(Nr+1)·C, busy low that cycle. A start in that cycle gives RUN at the next cycle with no idle gap.
- All outputs registered or decoded from registered state only; no combinational path from inputs to outputs.

## Structure
- Package aes_seq_pkg holds:
  - key_len encodings, NR_128/192/256, RCON_LAST_128/192/256;
  - state enum;
  - functions xtime and inv_xtime.
- Sub-module rcon_gen: 8-bit register with load value, step, and dir inputs; instantiated once.
- Slot and column counters plus FSM live in the top.

## Test plan
- C=1, AES-128 enc: start at T, rcon_step every RUN cycle from T+1 → rcon 02,04,…,80,1b,36 after 9 steps; final_rnd at T+11 with rnd_idx=10; done at T+12.
- C=1, AES-256 dec: start → rcon=0x40; 6 steps → 0x01; 7th step → 0x8d; final_rnd at rnd_idx=14; done at T+16.
- C=4, AES-192 enc: col_idx cycles 0..3; rnd_tick every 4th cycle; 13 slots; done at T+53; rcon_step while IDLE after done leaves rcon unchanged.
- start pulsed mid-RUN (rnd_idx=3) ignored, no restart. start in the done cycle restarts: rnd_idx=0 and first_rnd at the next cycle.
- Async rst asserted at rnd_idx=5, mid-clock → all outputs reset immediately, rcon 0x01, no done.
- key_len=11 with decrypt=1 → Nr=10, initial rcon 0x36. start and rcon_step in the same cycle → rcon 0x36, not stepped.
